// File: rtl/sar_adc_averager.sv
// Boxcar averager for SAR ADC codes: 1/2/4/8-sample windows feeding a small output FIFO.
// Optional ADC_WINDOW_DET_EN adds a threshold window detector on pushed averages.
module sar_adc_averager #(
    parameter int unsigned NUM_BITS   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_BITS-1:0]              d_in,
    input  logic                             eoc,
    input  logic [1:0]                       avg_sel,
    input  logic                             clr_ovf,
    output logic [NUM_BITS-1:0]              avg_data,
    output logic                             avg_valid,
    input  logic                             avg_ready,
    output logic [$clog2(FIFO_DEPTH):0]      level,
    output logic                             overflow
`ifdef ADC_WINDOW_DET_EN
    ,
    input  logic [NUM_BITS-1:0]              lo_thr,
    input  logic [NUM_BITS-1:0]              hi_thr,
    output logic                             out_of_range
`endif
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned ACC_W = NUM_BITS + 3;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  eoc_q;
    logic                  sample;
    logic                  start;
    logic                  add;
    logic                  push;
    logic [1:0]            n_sel;
    logic [ACC_W-1:0]      acc;
    logic [3:0]            cnt;
    logic [NUM_BITS-1:0]   avg_c;
    logic [NUM_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [LW-1:0]         level_nxt;

    function automatic logic [3:0] win_len(input logic [1:0] sel);
        return 4'd1 << sel;
    endfunction

    assign sample = eoc & ~eoc_q;
    assign avg_c  = NUM_BITS'(acc >> n_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            eoc_q <= 1'b0;
        end else begin
            state <= state_nxt;
            eoc_q <= eoc;
        end
    end

    // DONE pushes the finished window and may simultaneously open the next one.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        add       = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    start     = 1'b1;
                    state_nxt = (avg_sel == 2'd0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (sample) begin
                    add = 1'b1;
                    if (4'(cnt + 4'd1) == win_len(n_sel)) state_nxt = DONE;
                end
            end
            DONE: begin
                push = 1'b1;
                if (sample) begin
                    start     = 1'b1;
                    state_nxt = (avg_sel == 2'd0) ? DONE : ACCUM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_sel <= 2'd0;
            acc   <= '0;
            cnt   <= 4'd0;
        end else if (start) begin
            n_sel <= avg_sel;
            acc   <= ACC_W'(d_in);
            cnt   <= 4'd1;
        end else if (add) begin
            acc   <= acc + ACC_W'(d_in);
            cnt   <= cnt + 4'd1;
        end
    end

    assign pop       = avg_valid & avg_ready;
    assign full      = (level == LW'(FIFO_DEPTH));
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign level_nxt = level + LW'(push_ok) - LW'(pop);
    assign avg_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            avg_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= avg_c;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level     <= level_nxt;
            avg_valid <= (level_nxt != '0);
            // A drop wins over a simultaneous clear so no loss goes unreported.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

`ifdef ADC_WINDOW_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_of_range <= 1'b0;
        else        out_of_range <= push_ok & ((avg_c < lo_thr) | (avg_c > hi_thr));
    end
`endif

endmodule

// File: tb/tb_sar_adc_averager.sv
// Randomised + directed bench for sar_adc_averager against a queue-based window/FIFO model.
// Define ADC_WINDOW_DET_EN to also exercise the threshold detector.
module tb_sar_adc_averager;

    localparam int NB    = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB-1:0]     d_in;
    logic              eoc;
    logic [1:0]        avg_sel;
    logic              clr_ovf;
    logic [NB-1:0]     avg_data;
    logic              avg_valid;
    logic              avg_ready;
    logic [2:0]        level;
    logic              overflow;
`ifdef ADC_WINDOW_DET_EN
    logic [NB-1:0]     lo_thr;
    logic [NB-1:0]     hi_thr;
    logic              out_of_range;
    bit                m_oor;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int mq[$];
    int win[$];
    int win_n;
    bit pend;
    int pend_val;
    bit m_ovf;
    bit m_prev_eoc;

    sar_adc_averager #(.NUM_BITS(NB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .eoc       (eoc),
        .avg_sel   (avg_sel),
        .clr_ovf   (clr_ovf),
        .avg_data  (avg_data),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .level     (level),
        .overflow  (overflow)
`ifdef ADC_WINDOW_DET_EN
        ,
        .lo_thr       (lo_thr),
        .hi_thr       (hi_thr),
        .out_of_range (out_of_range)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        win.delete();
        win_n      = 1;
        pend       = 1'b0;
        pend_val   = 0;
        m_ovf      = 1'b0;
        m_prev_eoc = 1'b0;
`ifdef ADC_WINDOW_DET_EN
        m_oor      = 1'b0;
`endif
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT and compare.
    task automatic step();
        bit pop, full, drop, pushed;
        int sum;
        full   = (mq.size() == DEPTH);
        pop    = (mq.size() > 0) && avg_ready;
        drop   = 1'b0;
        pushed = 1'b0;
        if (pop) void'(mq.pop_front());
        if (pend) begin
            if (!full || pop) begin
                mq.push_back(pend_val);
                pushed = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
`ifdef ADC_WINDOW_DET_EN
        m_oor = pushed && (pend_val < int'(lo_thr) || pend_val > int'(hi_thr));
`endif
        if (drop)         m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        pend = 1'b0;
        if (eoc && !m_prev_eoc) begin
            if (win.size() == 0) win_n = 1 << avg_sel;
            win.push_back(int'(d_in));
            if (win.size() == win_n) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                pend     = 1'b1;
                pend_val = sum / win_n;
                win.delete();
            end
        end
        m_prev_eoc = eoc;
        @(posedge clk);
        #1;
        check("valid", 32'(avg_valid), 32'(mq.size() != 0));
        check("level", 32'(level), 32'(mq.size()));
        if (mq.size() > 0) check("data", 32'(avg_data), 32'(mq[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef ADC_WINDOW_DET_EN
        check("oor", 32'(out_of_range), 32'(m_oor));
`endif
    endtask

    task automatic sample(input int code);
        d_in = NB'(code);
        eoc  = 1'b1;
        step();
        eoc  = 1'b0;
        step();
    endtask

    task automatic do_reset();
        eoc   = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_valid", 32'(avg_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", 32'(avg_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        d_in      = '0;
        eoc       = 1'b0;
        avg_sel   = 2'd0;
        clr_ovf   = 1'b0;
        avg_ready = 1'b1;
`ifdef ADC_WINDOW_DET_EN
        lo_thr    = NB'(4);
        hi_thr    = NB'(10);
`endif
        do_reset();
        step();

        // Single-sample windows pass straight through
        sample(5);
        check("pass5", 32'(avg_data), 32'd5);
        sample(9);
        check("pass9", 32'(avg_data), 32'd9);
        repeat (2) step();

        // Four-sample window; mid-window avg_sel change is ignored
        avg_sel   = 2'd2;
        avg_ready = 1'b0;
        sample(3);
        sample(4);
        avg_sel = 2'd3;
        sample(4);
        sample(6);
        check("avg4", 32'(avg_data), 32'd4);
        check("avg4_level", 32'(level), 32'd1);
        avg_ready = 1'b1;
        repeat (2) step();

        // Fill, overflow, clear, drain in order
        avg_sel   = 2'd0;
        avg_ready = 1'b0;
        for (int i = 1; i <= 5; i++) sample(i);
        check("full_level", 32'(level), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        avg_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("pop_order", 32'(avg_data), 32'(i));
            step();
        end
        step();

        // Push into a full FIFO on the same cycle as a pop
        avg_ready = 1'b0;
        for (int i = 1; i <= 4; i++) sample(i + 8);
        d_in = NB'(7);
        eoc  = 1'b1;
        step();
        eoc       = 1'b0;
        avg_ready = 1'b1;
        step();
        avg_ready = 1'b0;
        check("full_pp_level", 32'(level), 32'd4);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        avg_ready = 1'b1;
        repeat (5) step();

        // Reset mid-window discards the partial sum
        avg_sel = 2'd3;
        for (int i = 0; i < 5; i++) sample($urandom_range(0, 15));
        do_reset();
        for (int i = 0; i < 8; i++) sample(15);
        check("avg15", 32'(avg_data), 32'd15);
        repeat (2) step();

`ifdef ADC_WINDOW_DET_EN
        avg_sel = 2'd0;
        sample(3);
        check("oor3", 32'(out_of_range), 32'd1);
        sample(7);
        check("oor7", 32'(out_of_range), 32'd0);
        sample(11);
        check("oor11", 32'(out_of_range), 32'd1);
        repeat (2) step();
        lo_thr = NB'($urandom_range(0, 7));
        hi_thr = NB'($urandom_range(8, 15));
`endif

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            eoc       = 1'($urandom_range(0, 1));
            d_in      = NB'($urandom_range(0, 15));
            avg_sel   = 2'($urandom_range(0, 3));
            avg_ready = ($urandom_range(0, 3) == 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
